// File: rtl/calc_op_sequencer.sv
// Calculator arithmetic sequencer: one-cycle ADD/SUB, iterative shift-add MULT and
// restoring DIV, plus the running previous-result register used by the ToPrev opcodes.
module calc_op_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             clear_prev,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] prev_value,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0]  OP_ADD  = 2'b00;
  localparam logic [1:0]  OP_SUB  = 2'b01;
  localparam logic [1:0]  OP_MULT = 2'b10;
  localparam logic [1:0]  OP_DIV  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_DIVZ} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // MULT high half / DIV remainder
  logic [WIDTH-1:0]   sh_q, sh_d;       // A operand, MULT low half / DIV quotient
  logic [WIDTH-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   prev_eff, a_sel, b_sel;
  logic [WIDTH:0]     add_sum, sub_diff, mul_sum, div_sh;
  logic [WIDTH-1:0]   mul_hi, mul_lo, div_rem, div_quo;
  logic               div_ge, last_iter;

  // Datapath for every compute state; only the active state consumes its terms.
  always_comb begin
    prev_eff  = clear_prev ? '0 : prev_q;
    add_sum   = {1'b0, sh_q} + {1'b0, b_q};
    sub_diff  = {1'b0, sh_q} - {1'b0, b_q};
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], sh_q[WIDTH-1:1]};
    div_sh    = {acc_q, sh_q[WIDTH-1]};
    div_ge    = (div_sh >= {1'b0, b_q});
    div_rem   = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
    div_quo   = (sh_q << 1) | WIDTH'(div_ge);
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    prev_d   = prev_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    a_sel    = '0;
    b_sel    = '0;

    case (state_q)
      S_IDLE: begin
        if (clear_prev) prev_d = '0;
        if (funct[2]) begin
          a_sel = operand_a;
          b_sel = operand_b;
        end else if (funct[1:0] == OP_DIV) begin
          a_sel = operand_b;
          b_sel = prev_eff;
        end else begin
          a_sel = prev_eff;
          b_sel = operand_b;
        end
        if (start) begin
          op_d   = funct[1:0];
          sh_d   = a_sel;
          b_d    = b_sel;
          acc_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          case (funct[1:0])
            OP_ADD, OP_SUB: state_d = S_ADDSUB;
            OP_MULT:        state_d = S_MUL;
            default:        state_d = (b_sel == '0) ? S_DIVZ : S_DIV;
          endcase
        end
      end
      S_ADDSUB: begin
        if (op_q == OP_SUB) begin
          result_d = sub_diff[WIDTH-1:0];
          ovf_d    = sub_diff[WIDTH];
        end else begin
          result_d = add_sum[WIDTH-1:0];
          ovf_d    = add_sum[WIDTH];
        end
        prev_d  = result_d;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_MUL: begin
        acc_d = mul_hi;
        sh_d  = mul_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d    = '0;
          result_d = mul_lo;
          ovf_d    = |mul_hi;
          prev_d   = mul_lo;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_rem;
        sh_d  = div_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d    = '0;
          result_d = div_quo;
          ovf_d    = 1'b0;
          prev_d   = div_quo;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_DIVZ: begin
        // Divide-by-zero leaves the previous result untouched.
        result_d = '1;
        ovf_d    = 1'b0;
        dbz_d    = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      prev_q   <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      prev_q   <= prev_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign prev_value  = prev_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer (WIDTH=8): latency, arithmetic, flags,
// previous-result handling, busy/start interplay and asynchronous reset.
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] funct;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       clear_prev;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] prev_value;
  logic       overflow;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  calc_op_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b), .clear_prev(clear_prev),
    .busy(busy), .done(done), .result(result), .prev_value(prev_value),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one op from a negedge; returns at the negedge of the done cycle.
  // lat = rising edges from the accept edge to the edge that raised done.
  task automatic run_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic clr, output int lat);
    funct = f; operand_a = a; operand_b = b; clear_prev = clr; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; clear_prev = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL busy_after_accept got=%b want=1", busy);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 64);
    checks++;
    if (lat >= 64) begin
      failures++; $display("FAIL done_timeout funct=%b", f);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; funct = '0; operand_a = '0; operand_b = '0; clear_prev = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, overflow, div_by_zero, result, prev_value} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b %0d %0d want all zero",
               busy, done, overflow, div_by_zero, result, prev_value);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    run_op(3'b100, 8'd200, 8'd100, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d want=1", lat); end
    checks++; if (result !== 8'd44) begin failures++; $display("FAIL add_result got=%0d want=44", result); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL add_overflow got=%b want=1", overflow); end
    checks++; if (prev_value !== 8'd44) begin failures++; $display("FAIL add_prev got=%0d want=44", prev_value); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy_in_done got=%b want=0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b want=0", done); end
  endtask

  task automatic test_mult();
    int lat;
    run_op(3'b110, 8'd13, 8'd11, 1'b0, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL mult_latency got=%0d want=8", lat); end
    checks++; if (result !== 8'd143) begin failures++; $display("FAIL mult_result got=%0d want=143", result); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mult_overflow got=%b want=0", overflow); end
    run_op(3'b010, 8'hFF, 8'd2, 1'b0, lat);
    checks++; if (result !== 8'd30) begin failures++; $display("FAIL mulprev_result got=%0d want=30", result); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL mulprev_overflow got=%b want=1", overflow); end
    checks++; if (prev_value !== 8'd30) begin failures++; $display("FAIL mulprev_prev got=%0d want=30", prev_value); end
  endtask

  task automatic test_div();
    int lat;
    run_op(3'b111, 8'd100, 8'd7, 1'b0, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL div_latency got=%0d want=8", lat); end
    checks++; if (result !== 8'd14) begin failures++; $display("FAIL div_result got=%0d want=14", result); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL div_overflow got=%b want=0", overflow); end
    run_op(3'b111, 8'd9, 8'd0, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL divz_latency got=%0d want=1", lat); end
    checks++; if (result !== 8'd255) begin failures++; $display("FAIL divz_result got=%0d want=255", result); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL divz_flag got=%b want=1", div_by_zero); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL divz_overflow got=%b want=0", overflow); end
    checks++; if (prev_value !== 8'd14) begin failures++; $display("FAIL divz_prev got=%0d want=14", prev_value); end
    run_op(3'b100, 8'd1, 8'd1, 1'b0, lat);
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL divz_clear got=%b want=0", div_by_zero); end
    checks++; if (result !== 8'd2) begin failures++; $display("FAIL after_divz_result got=%0d want=2", result); end
  endtask

  task automatic test_div_by_prev();
    int lat;
    run_op(3'b100, 8'd2, 8'd4, 1'b0, lat);
    run_op(3'b011, 8'd99, 8'd45, 1'b0, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL divprev_latency got=%0d want=8", lat); end
    checks++; if (result !== 8'd7) begin failures++; $display("FAIL divprev_result got=%0d want=7", result); end
    checks++; if (prev_value !== 8'd7) begin failures++; $display("FAIL divprev_prev got=%0d want=7", prev_value); end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    funct = 3'b110; operand_a = 8'd5; operand_b = 8'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) begin funct = 3'b100; operand_a = 8'd1; operand_b = 8'd1; start = 1'b1; end
      if (i == 3) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL busy_ignore_dones got=%0d want=1", ndone); end
    checks++; if (result !== 8'd30) begin failures++; $display("FAIL busy_ignore_result got=%0d want=30", result); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(3'b100, 8'd10, 8'd20, 1'b0, lat);
    checks++; if (result !== 8'd30) begin failures++; $display("FAIL b2b_first got=%0d want=30", result); end
    run_op(3'b101, 8'd50, 8'd8, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_latency got=%0d want=1", lat); end
    checks++; if (result !== 8'd42) begin failures++; $display("FAIL b2b_result got=%0d want=42", result); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_reset_mid();
    int lat, ndone;
    funct = 3'b110; operand_a = 8'd200; operand_b = 8'd200; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overflow, div_by_zero, result, prev_value} !== 20'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b%b%b%b %0d %0d want all zero",
               busy, done, overflow, div_by_zero, result, prev_value);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d want=0", ndone); end
    run_op(3'b100, 8'd3, 8'd4, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL post_reset_latency got=%0d want=1", lat); end
    checks++; if (result !== 8'd7) begin failures++; $display("FAIL post_reset_result got=%0d want=7", result); end
  endtask

  task automatic test_clear_prev();
    int lat;
    run_op(3'b100, 8'd25, 8'd25, 1'b0, lat);
    checks++; if (prev_value !== 8'd50) begin failures++; $display("FAIL setup_prev got=%0d want=50", prev_value); end
    run_op(3'b000, 8'd77, 8'd5, 1'b1, lat);
    checks++; if (result !== 8'd5) begin failures++; $display("FAIL clear_addprev got=%0d want=5", result); end
    run_op(3'b001, 8'd77, 8'd9, 1'b0, lat);
    checks++; if (result !== 8'd252) begin failures++; $display("FAIL subprev_result got=%0d want=252", result); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL subprev_overflow got=%b want=1", overflow); end
    @(negedge clk);
    clear_prev = 1'b1;
    @(negedge clk);
    clear_prev = 1'b0;
    checks++; if (prev_value !== 8'd0) begin failures++; $display("FAIL clear_idle got=%0d want=0", prev_value); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_div();
    test_div_by_prev();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_clear_prev();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
